seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Multi-cycle unsigned restoring divider and the inverse datapath of the approximate 4x4 multiplier. It takes a 2*WIDTH-bit dividend (the multiplier's product width) and a WIDTH-bit divisor, and returns the quotient and remainder. The result is exact, so the verification environment uses it to recover operands from multiplier products and to measure approximation error.
- Valid/ready handshake on both input and output sides.
- Fixed latency, one quotient bit resolved per cycle.

Parameters:
WIDTH, 4, divisor and remainder width; dividend and quotient are 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
in_valid_i  input  1  dividend_i and divisor_i are valid.
in_ready_o  output  1  block can accept an operation.
dividend_i  input  2*WIDTH  unsigned dividend.
divisor_i  input  WIDTH  unsigned divisor.
out_valid_o  output  1  result outputs are valid.
out_ready_i  input  1  consumer accepts the result.
quotient_o  output  2*WIDTH  unsigned quotient.
remainder_o  output  WIDTH  unsigned remainder.
div_zero_o  output  1  result came from a zero divisor; valid with out_valid_o.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; in_ready_o=1; out_valid_o=0.
  - quotient_o, remainder_o and div_zero_o = 0; internal registers and step counter = 0.
  - Reset mid-CALC or mid-DONE abandons the operation and emits no result.
- State IDLE:
  - in_ready_o=1, out_valid_o=0.
  - Accept when in_valid_i && in_ready_o at a clock edge: latch dividend into the shift register, divisor into D, R(WIDTH+1 bits)=0, counter=0, zflag=(divisor_i==0). Go to CALC.
- State CALC: in_ready_o=0, out_valid_o=0. Each cycle performs one restoring step:
  - shifted = {R[WIDTH-1:0], Q_msb}, where Q_msb is the current MSB of the dividend/quotient shift register.
  - trial = shifted - {1'b0,D}, computed in WIDTH+2 bits.
  - If trial is non-negative: R=trial[WIDTH:0] and the quotient bit is 1. Otherwise R=shifted and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the shift register; counter increments.
  - After 2*WIDTH steps (counter==2*WIDTH-1 on the step edge), register the results and go to DONE.
- Result registration:
  - Normal: quotient_o = shift register; remainder_o = R[WIDTH-1:0].
  - zflag==1: quotient_o = all ones; remainder_o = dividend[WIDTH-1:0]; div_zero_o=1. Latency is unchanged.
- State DONE:
  - out_valid_o=1, in_ready_o=0.
  - Outputs stay stable while out_ready_i==0, with unlimited backpressure.
  - On out_valid_o && out_ready_i: return to IDLE, out_valid_o=0. Output data holds its last value and is don't-care.
- Latency and throughput:
  - If the accept happens on edge k, out_valid_o rises after edge k+2*WIDTH (8 cycles at default).
  - No overlap between operations: the next accept is possible at the earliest on the edge after the output handshake.
  - Throughput is one operation per 2*WIDTH+2 cycles.
- Inputs:
  - in_valid_i outside IDLE is ignored; the upstream side must hold its data.
  - dividend_i and divisor_i are only sampled at accept.
- Invariants:
  - The remainder is always < divisor when the divisor is non-zero.
  - quotient*divisor + remainder == dividend.
  - No overflow is possible because the quotient width equals the dividend width.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t.
  - Default WIDTH localparam.
  - Helper function clog2-based counter width, $clog2(2*WIDTH).
- One combinational sub-module, div_restore_step:
  - Inputs: R, incoming bit, D.
  - Outputs: next R, quotient bit.
  - Parameterised by WIDTH.

Test Plan:
1. Reset held for 2 cycles, then released -> in_ready_o=1, out_valid_o=0, quotient_o=0, remainder_o=0, div_zero_o=0.
2. dividend=225, divisor=15, out_ready_i=1 -> out_valid_o rises exactly 8 cycles after accept; quotient=15, remainder=0, div_zero=0.
3. Sweep i=0..15 with dividend=i*i and divisor=i (i>0) -> quotient=i, remainder=0 each time; 200/7 -> 28 r4; 5/9 -> 0 r5.
4. dividend=100, divisor=0 -> after 8 cycles quotient=255, remainder=4, div_zero_o=1.
5. Backpressure: 200/7 with out_ready_i=0 for 5 cycles after out_valid_o -> outputs stable and in_ready_o=0 throughout; a new in_valid_i in that window is not accepted; the handshake returns the block to IDLE the next cycle.
6. rst driven low for one edge at step 3 of CALC -> block is in IDLE next cycle with outputs zeroed and no out_valid_o pulse; a subsequent 225/15 completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract D.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    // The top bit of R never feeds the next step; only the low WIDTH bits shift up.
    logic             unused_r_msb;

    assign unused_r_msb = r[WIDTH];

    always_comb begin
        shifted = {1'b0, r[WIDTH-1:0], in_bit};
        trial   = shifted - {2'b00, d};
        q_bit   = ~trial[WIDTH+1];
        r_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for a new operation
//   CALC  | 2*WIDTH restoring steps in progress
//   DONE  | result held until the consumer accepts it
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2*WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]     remainder_o,
    output logic                 div_zero_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * WIDTH - 1);

    div_state_t         state, state_nxt;
    logic [2*WIDTH-1:0] shreg;
    logic [WIDTH-1:0]   d_reg;
    logic [WIDTH:0]     r_reg;
    logic [WIDTH-1:0]   div_lo;
    logic [CW-1:0]      cnt;
    logic               zflag;
    logic [WIDTH:0]     r_next;
    logic               q_bit;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_reg),
        .in_bit (shreg[2*WIDTH-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            div_lo      <= '0;
            cnt         <= '0;
            zflag       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        shreg  <= dividend_i;
                        d_reg  <= divisor_i;
                        r_reg  <= '0;
                        div_lo <= dividend_i[WIDTH-1:0];
                        cnt    <= '0;
                        zflag  <= (divisor_i == '0);
                    end
                end
                CALC: begin
                    shreg <= {shreg[2*WIDTH-2:0], q_bit};
                    r_reg <= r_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        // A zero divisor reports all-ones with the dividend's low bits as remainder.
                        if (zflag) begin
                            quotient_o  <= '1;
                            remainder_o <= div_lo;
                        end else begin
                            quotient_o  <= {shreg[2*WIDTH-2:0], q_bit};
                            remainder_o <= r_next[WIDTH-1:0];
                        end
                        div_zero_o <= zflag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard testbench for seq_restoring_divider at WIDTH=4.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [2*W-1:0] dividend_i;
    logic [W-1:0]   divisor_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [2*W-1:0] quotient_o;
    logic [W-1:0]   remainder_o;
    logic           div_zero_o;

    typedef struct {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div_zero_o  (div_zero_o)
    );

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a[W-1:0];
            e.z = 1'b1;
        end else begin
            e.q = a / {4'b0, b};
            e.r = W'(a % {4'b0, b});
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Waits for in_ready (bounded), presents one operation and records its expected result.
    task automatic send_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid_i = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        sb.push_back(model(a, b));
    endtask

    // Cycles from the accept edge to out_valid_o; -1 if it never arrives.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid_o && lat < 40);
        if (!out_valid_o) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        dividend_i = '0;
        divisor_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        checks++; if (quotient_o !== '0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient_o); end
        checks++; if (remainder_o !== '0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder_o); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero_o); end
    endtask

    task automatic test_basic();
        int lat;
        exp_t e;
        out_ready_i = 1'b1;
        send_op(8'd225, 4'd15);
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (quotient_o !== 8'd15 || e.q !== 8'd15) begin errors++; $display("FAIL basic_quotient: got %0d expected 15", quotient_o); end
        checks++; if (remainder_o !== e.r) begin errors++; $display("FAIL basic_remainder: got %0d expected %0d", remainder_o, e.r); end
        checks++; if (div_zero_o !== e.z) begin errors++; $display("FAIL basic_div_zero: got %b expected %b", div_zero_o, e.z); end
        @(posedge clk); #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL basic_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid_o, in_ready_o); end
    endtask

    task automatic test_sweep();
        logic [2*W-1:0] dvd [0:16];
        logic [W-1:0]   dvs [0:16];
        int lat;
        exp_t e;
        for (int i = 1; i <= 15; i++) begin
            dvd[i-1] = 8'(i * i);
            dvs[i-1] = 4'(i);
        end
        dvd[15] = 8'd200; dvs[15] = 4'd7;
        dvd[16] = 8'd5;   dvs[16] = 4'd9;
        out_ready_i = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            send_op(dvd[k], dvs[k]);
            wait_result(lat);
            e = sb.pop_front();
            checks++; if (lat !== 8) begin errors++; $display("FAIL sweep_latency %0d/%0d: got %0d expected 8", dvd[k], dvs[k], lat); end
            checks++; if (quotient_o !== e.q) begin errors++; $display("FAIL sweep_quotient %0d/%0d: got %0d expected %0d", dvd[k], dvs[k], quotient_o, e.q); end
            checks++; if (remainder_o !== e.r) begin errors++; $display("FAIL sweep_remainder %0d/%0d: got %0d expected %0d", dvd[k], dvs[k], remainder_o, e.r); end
            checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL sweep_div_zero %0d/%0d: got %b expected 0", dvd[k], dvs[k], div_zero_o); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        exp_t e;
        out_ready_i = 1'b1;
        send_op(8'd100, 4'd0);
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat !== 8) begin errors++; $display("FAIL dz_latency: got %0d expected 8", lat); end
        checks++; if (quotient_o !== 8'd255 || e.q !== 8'd255) begin errors++; $display("FAIL dz_quotient: got %0d expected 255", quotient_o); end
        checks++; if (remainder_o !== 4'd4 || e.r !== 4'd4) begin errors++; $display("FAIL dz_remainder: got %0d expected 4", remainder_o); end
        checks++; if (div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        out_ready_i = 1'b0;
        send_op(8'd200, 4'd7);
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid_i = 1'b1;
            dividend_i = 8'd3;
            divisor_i  = 4'd1;
            @(posedge clk); #1;
            checks++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_flags cycle %0d: got valid=%b ready=%b expected valid=1 ready=0", c, out_valid_o, in_ready_o); end
            checks++; if (quotient_o !== e.q || remainder_o !== e.r || div_zero_o !== e.z) begin errors++; $display("FAIL bp_hold cycle %0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", c, quotient_o, remainder_o, div_zero_o, e.q, e.r, e.z); end
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid_o, in_ready_o); end
        @(posedge clk); #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got valid=%b ready=%b expected valid=0 ready=1", out_valid_o, in_ready_o); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen = 0;
        exp_t e;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        dividend_i = 8'd200;
        divisor_i  = 4'd7;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ready=%b valid=%b expected ready=1 valid=0", in_ready_o, out_valid_o); end
        checks++; if (quotient_o !== '0 || remainder_o !== '0 || div_zero_o !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got q=%0d r=%0d z=%b expected all 0", quotient_o, remainder_o, div_zero_o); end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d valid cycles expected 0", seen); end
        send_op(8'd225, 4'd15);
        wait_result(lat);
        e = sb.pop_front();
        checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 8", lat); end
        checks++; if (quotient_o !== e.q || remainder_o !== e.r || div_zero_o !== e.z) begin errors++; $display("FAIL midrst_after_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", quotient_o, remainder_o, div_zero_o, e.q, e.r, e.z); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int acc [0:2];
        exp_t e;
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_op(8'(37 + 60 * k), 4'(3 + 5 * k));
            acc[k] = cyc;
            wait_result(lat);
            e = sb.pop_front();
            checks++; if (quotient_o !== e.q || remainder_o !== e.r || div_zero_o !== e.z) begin errors++; $display("FAIL b2b_result %0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", k, quotient_o, remainder_o, div_zero_o, e.q, e.r, e.z); end
        end
        checks++; if (acc[1] - acc[0] !== 10 || acc[2] - acc[1] !== 10) begin errors++; $display("FAIL b2b_interval: got %0d,%0d cycles expected 10,10", acc[1] - acc[0], acc[2] - acc[1]); end
        @(posedge clk); #1;
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
